// File: rtl/fwuart_pkg.sv
// Shared types and helpers for the fwuart transmit-side arbiter: state encoding,
// default byte width and the round-robin winner search.
package fwuart_pkg;

  localparam int FWUART_DATA_WIDTH = 8;

  // Upper bound on requesters; rr_pick works on this width and callers zero-extend.
  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = 3;

  typedef logic [RR_IDX_W:0] rr_cnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] valid,
    input logic [RR_IDX_W-1:0]   ptr,
    input rr_cnt_t               n_req
  );
    rr_cnt_t                idx;
    logic [RR_IDX_W-1:0]    win;
    logic                   found;
    win   = '0;
    found = 1'b0;
    // ptr < n_req and k < n_req, so a single subtract is enough to wrap
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      idx = {1'b0, ptr} + rr_cnt_t'(k);
      if (idx >= n_req) begin
        idx = idx - n_req;
      end
      if (!found && (k < int'(n_req)) && valid[idx[RR_IDX_W-1:0]]) begin
        win   = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fwuart_rr_pick.sv
// Combinational rotating-priority picker: first valid requester at or after ptr,
// wrapping modulo N_REQ.
module fwuart_rr_pick
  import fwuart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any_valid,
  output logic [IDX_W-1:0] winner
);

  logic [RR_IDX_W-1:0] pick;

  always_comb begin
    pick      = rr_pick(RR_MAX_REQ'(valid), RR_IDX_W'(ptr), rr_cnt_t'(N_REQ));
    winner    = IDX_W'(pick);
    any_valid = |valid;
  end

endmodule

// File: rtl/fwuart_tx_arb.sv
// Round-robin arbiter sharing one fwuart_tx byte channel between N_REQ message
// sources; a grant is held until the source's last beat or the burst limit.
module fwuart_tx_arb
  import fwuart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = FWUART_DATA_WIDTH,
  parameter int MAX_BURST  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_data,
  input  logic [N_REQ-1:0]              i_valid,
  input  logic [N_REQ-1:0]              i_last,
  output logic [N_REQ-1:0]              i_ready,
  output logic [DATA_WIDTH-1:0]         t_data,
  output logic                          t_valid,
  input  logic                          t_ready,
  output logic                          busy,
  output logic [$clog2(N_REQ)-1:0]      gnt_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  busy_q, busy_d;

  logic                  any_valid;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      next_ptr;
  logic                  xfer;
  logic                  release_now;
  logic [DATA_WIDTH-1:0] req_data [N_REQ];

  fwuart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid     (i_valid),
    .ptr       (rr_ptr_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_data[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pass-through mux: the granted source talks straight to fwuart_tx, no buffering
  always_comb begin
    t_data  = '0;
    t_valid = 1'b0;
    i_ready = '0;
    if (state_q == GRANT) begin
      t_data           = req_data[gnt_id_q];
      t_valid          = i_valid[gnt_id_q];
      i_ready[gnt_id_q] = t_ready;
    end
  end

  always_comb begin
    xfer        = (state_q == GRANT) && t_valid && t_ready;
    release_now = xfer && (i_last[gnt_id_q] ||
                           ((MAX_BURST != 0) && (beat_cnt_q == BURST_LAST)));
    next_ptr    = (gnt_id_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = GRANT;
          gnt_id_d   = winner;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (xfer && (beat_cnt_q != CNT_MAX)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_fwuart_tx_arb.sv
// Directed bench for fwuart_tx_arb: one unlimited-burst instance and one with
// MAX_BURST=4, driven after the rising edge and sampled on the falling edge.
module tb_fwuart_tx_arb;

  logic clock = 1'b0;
  logic reset;

  logic [31:0] a_data;
  logic [3:0]  a_valid, a_last, a_rdy;
  logic [7:0]  a_tdata;
  logic        a_tvalid, a_tready, a_busy;
  logic [1:0]  a_gnt;

  logic [31:0] b_data;
  logic [3:0]  b_valid, b_last, b_rdy;
  logic [7:0]  b_tdata;
  logic        b_tvalid, b_tready, b_busy;
  logic [1:0]  b_gnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fwuart_tx_arb #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(0)) dut_a (
    .clock(clock), .reset(reset), .i_data(a_data), .i_valid(a_valid), .i_last(a_last),
    .i_ready(a_rdy), .t_data(a_tdata), .t_valid(a_tvalid), .t_ready(a_tready),
    .busy(a_busy), .gnt_id(a_gnt)
  );

  fwuart_tx_arb #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_b (
    .clock(clock), .reset(reset), .i_data(b_data), .i_valid(b_valid), .i_last(b_last),
    .i_ready(b_rdy), .t_data(b_tdata), .t_valid(b_tvalid), .t_ready(b_tready),
    .busy(b_busy), .gnt_id(b_gnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_data = '0; a_valid = '0; a_last = '0; a_tready = 1'b0;
    b_data = '0; b_valid = '0; b_last = '0; b_tready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 4'b1111; a_tready = 1'b1;
    b_valid = 4'b1111; b_tready = 1'b1;
    tick();
    tick();
    @(negedge clock);
    total++; if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", a_busy); end
    total++; if (a_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got=%0b exp=0", a_tvalid); end
    total++; if (a_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL reset_iready got=%b exp=0000", a_rdy); end
    total++; if (a_gnt !== 2'd0) begin bad++; $display("[TB] FAIL reset_gnt got=%0d exp=0", a_gnt); end
    total++; if (b_busy !== 1'b0 || b_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_b busy=%0b tvalid=%0b exp=0,0", b_busy, b_tvalid); end
    do_reset();
  endtask

  task automatic test_single_msg();
    do_reset();
    a_valid = 4'b0001; a_data[7:0] = 8'h41; a_last = 4'b0000; a_tready = 1'b1;
    @(negedge clock);
    total++; if (a_tvalid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle tvalid=%0b busy=%0b exp=0,0", a_tvalid, a_busy); end
    tick();
    @(negedge clock);
    total++; if (a_busy !== 1'b1 || a_gnt !== 2'd0) begin bad++; $display("[TB] FAIL single_grant busy=%0b gnt=%0d exp=1,0", a_busy, a_gnt); end
    total++; if (a_tvalid !== 1'b1 || a_tdata !== 8'h41) begin bad++; $display("[TB] FAIL single_b0 tvalid=%0b data=%h exp=1,41", a_tvalid, a_tdata); end
    total++; if (a_rdy !== 4'b0001) begin bad++; $display("[TB] FAIL single_rdy0 got=%b exp=0001", a_rdy); end
    tick();
    a_data[7:0] = 8'h42;
    @(negedge clock);
    total++; if (a_tdata !== 8'h42) begin bad++; $display("[TB] FAIL single_b1 got=%h exp=42", a_tdata); end
    tick();
    a_data[7:0] = 8'h43; a_last = 4'b0001;
    @(negedge clock);
    total++; if (a_tdata !== 8'h43 || a_rdy !== 4'b0001) begin bad++; $display("[TB] FAIL single_b2 data=%h rdy=%b exp=43,0001", a_tdata, a_rdy); end
    tick();
    a_valid = 4'b0011; a_last = 4'b0010; a_data[15:8] = 8'h51;
    @(negedge clock);
    total++; if (a_busy !== 1'b0 || a_tvalid !== 1'b0 || a_gnt !== 2'd0) begin bad++; $display("[TB] FAIL single_release busy=%0b tvalid=%0b gnt=%0d exp=0,0,0", a_busy, a_tvalid, a_gnt); end
    tick();
    @(negedge clock);
    total++; if (a_gnt !== 2'd1 || a_tdata !== 8'h51 || a_rdy !== 4'b0010) begin bad++; $display("[TB] FAIL single_rrptr gnt=%0d data=%h rdy=%b exp=1,51,0010", a_gnt, a_tdata, a_rdy); end
    tick();
    a_valid = 4'b0000; a_last = 4'b0000;
    @(negedge clock);
    total++; if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_end busy=%0b exp=0", a_busy); end
  endtask

  task automatic test_two_sources();
    do_reset();
    a_tready = 1'b1; a_valid = 4'b0101; a_last = 4'b0000;
    a_data[7:0] = 8'hA0; a_data[23:16] = 8'hC0;
    tick();
    @(negedge clock);
    total++; if (a_gnt !== 2'd0 || a_tdata !== 8'hA0 || a_rdy !== 4'b0001) begin bad++; $display("[TB] FAIL two_s0b0 gnt=%0d data=%h rdy=%b exp=0,a0,0001", a_gnt, a_tdata, a_rdy); end
    tick();
    a_data[7:0] = 8'hA1; a_last = 4'b0001;
    @(negedge clock);
    total++; if (a_gnt !== 2'd0 || a_tdata !== 8'hA1) begin bad++; $display("[TB] FAIL two_s0b1 gnt=%0d data=%h exp=0,a1", a_gnt, a_tdata); end
    tick();
    a_valid = 4'b0100; a_last = 4'b0000;
    @(negedge clock);
    total++; if (a_tvalid !== 1'b0 || a_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL two_gap tvalid=%0b rdy=%b exp=0,0000", a_tvalid, a_rdy); end
    tick();
    @(negedge clock);
    total++; if (a_gnt !== 2'd2 || a_tdata !== 8'hC0 || a_rdy !== 4'b0100) begin bad++; $display("[TB] FAIL two_s2b0 gnt=%0d data=%h rdy=%b exp=2,c0,0100", a_gnt, a_tdata, a_rdy); end
    tick();
    a_data[23:16] = 8'hC1; a_last = 4'b0100;
    @(negedge clock);
    total++; if (a_tdata !== 8'hC1) begin bad++; $display("[TB] FAIL two_s2b1 got=%h exp=c1", a_tdata); end
    tick();
    a_valid = 4'b0000; a_last = 4'b0000;
    @(negedge clock);
    total++; if (a_busy !== 1'b0) begin bad++; $display("[TB] FAIL two_end busy=%0b exp=0", a_busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] src;
    do_reset();
    a_tready = 1'b1; a_valid = 4'b1111; a_last = 4'b1111;
    a_data = 32'h33323130;
    for (int i = 0; i < 6; i++) begin
      src = 2'(i % 4);
      tick();
      @(negedge clock);
      total++; if (a_gnt !== src || a_tdata !== (8'h30 + 8'(src)) || a_rdy !== (4'b0001 << src)) begin
        bad++; $display("[TB] FAIL rr_grant%0d gnt=%0d data=%h rdy=%b exp=%0d", i, a_gnt, a_tdata, a_rdy, src);
      end
      tick();
      @(negedge clock);
      total++; if (a_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rr_idle%0d tvalid=%0b exp=0", i, a_tvalid); end
    end
    a_valid = 4'b0000;
  endtask

  task automatic test_burst_limit();
    logic [1:0] exp_src [11];
    logic [7:0] exp_dat [11];
    int sent1 = 0;
    int sent3 = 0;
    int idx = 0;
    exp_src = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hC3, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    do_reset();
    b_tready = 1'b1;
    for (int c = 0; c < 60 && idx < 11; c++) begin
      b_valid[1] = (sent1 < 10);
      b_data[15:8] = 8'(8'h10 + sent1);
      b_last[1] = (sent1 == 9);
      b_valid[3] = (sent3 < 1);
      b_data[31:24] = 8'hC3;
      b_last[3] = 1'b1;
      @(negedge clock);
      if (b_tvalid && b_tready) begin
        total++; if (b_gnt !== exp_src[idx] || b_tdata !== exp_dat[idx]) begin
          bad++; $display("[TB] FAIL burst_beat%0d gnt=%0d data=%h exp=%0d,%h", idx, b_gnt, b_tdata, exp_src[idx], exp_dat[idx]);
        end
        if (b_rdy[1] && b_valid[1]) sent1++;
        if (b_rdy[3] && b_valid[3]) sent3++;
        idx++;
      end
      tick();
    end
    total++; if (idx != 11) begin bad++; $display("[TB] FAIL burst_count got=%0d exp=11", idx); end
    b_valid = 4'b0000; b_last = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic       pat [4];
    logic [7:0] exp_d [4];
    int sent = 0;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_d = '{8'hD0, 8'hD1, 8'hD1, 8'hD1};
    do_reset();
    a_tready = 1'b1; a_valid = 4'b0011; a_last = 4'b0010;
    a_data[7:0] = 8'hD0; a_data[15:8] = 8'hE0;
    tick();
    for (int j = 0; j < 4; j++) begin
      a_tready = pat[j];
      a_data[7:0] = (sent == 0) ? 8'hD0 : 8'hD1;
      a_last[0] = (sent == 1);
      @(negedge clock);
      total++; if (a_rdy !== {3'b000, pat[j]} || a_tdata !== exp_d[j]) begin
        bad++; $display("[TB] FAIL bp_cyc%0d rdy=%b data=%h exp=%b,%h", j, a_rdy, a_tdata, {3'b000, pat[j]}, exp_d[j]);
      end
      if (a_rdy[0] && a_valid[0]) sent++;
      tick();
    end
    a_valid[0] = 1'b0;
    @(negedge clock);
    total++; if (sent != 2 || a_busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_done beats=%0d busy=%0b exp=2,0", sent, a_busy); end
    a_valid = 4'b0000; a_last = 4'b0000;
  endtask

  task automatic test_reset_mid_msg();
    do_reset();
    a_tready = 1'b1; a_valid = 4'b0100; a_last = 4'b0000; a_data[23:16] = 8'h60;
    tick();
    @(negedge clock);
    total++; if (a_gnt !== 2'd2 || a_tdata !== 8'h60) begin bad++; $display("[TB] FAIL rst_b0 gnt=%0d data=%h exp=2,60", a_gnt, a_tdata); end
    tick();
    a_data[23:16] = 8'h61;
    @(negedge clock);
    total++; if (a_tdata !== 8'h61) begin bad++; $display("[TB] FAIL rst_b1 got=%h exp=61", a_tdata); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_valid = 4'b1001; a_last = 4'b1001; a_data[7:0] = 8'h70; a_data[31:24] = 8'h73;
    @(negedge clock);
    total++; if (a_busy !== 1'b0 || a_tvalid !== 1'b0 || a_rdy !== 4'b0000 || a_gnt !== 2'd0) begin
      bad++; $display("[TB] FAIL rst_drop busy=%0b tvalid=%0b rdy=%b gnt=%0d exp=0,0,0000,0", a_busy, a_tvalid, a_rdy, a_gnt);
    end
    tick();
    @(negedge clock);
    total++; if (a_busy !== 1'b1 || a_gnt !== 2'd0 || a_tdata !== 8'h70) begin
      bad++; $display("[TB] FAIL rst_regrant busy=%0b gnt=%0d data=%h exp=1,0,70", a_busy, a_gnt, a_tdata);
    end
    tick();
    a_valid = 4'b0000; a_last = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    a_data = '0; a_valid = '0; a_last = '0; a_tready = 1'b0;
    b_data = '0; b_valid = '0; b_last = '0; b_tready = 1'b0;
    tick();
    test_reset();
    test_single_msg();
    test_two_sources();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_reset_mid_msg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
